// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding and default modulo constants for the stopwatch
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, SPLT = 2'd3} state_t;
  localparam int PRESCALE_DEF = 10;
  localparam int SEC_MOD_DEF  = 60;
  localparam int MIN_MOD_DEF  = 60;
endpackage

// File: rtl/count_clr.sv
// count_clr: modulo counter with synchronous clear taking priority over enable
module count_clr #(
  parameter int MOD = 10,
  parameter int W   = $clog2(MOD)
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         CLR,
  input  logic         ENABLE,
  output logic [W-1:0] COUNT,
  output logic         TC
);
  assign TC = COUNT == W'(MOD - 1);
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) COUNT <= '0;
    else if (CLR) COUNT <= '0;
    else if (ENABLE) COUNT <= TC ? '0 : COUNT + 1'b1;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/split stopwatch sequencing prescaler, seconds and minutes counters
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int SEC_MOD  = SEC_MOD_DEF,
  parameter int MIN_MOD  = MIN_MOD_DEF,
  parameter int NP       = $clog2(PRESCALE),
  parameter int NS       = $clog2(SEC_MOD),
  parameter int NM       = $clog2(MIN_MOD)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          START,
  input  logic          STOP,
  input  logic          CLEAR,
  input  logic          LAP,
  output logic [NS-1:0] SEC_OUT,
  output logic [NM-1:0] MIN_OUT,
  output logic          RUNNING,
  output logic          SPLIT,
  output logic          OVF
);
  state_t state, state_n;
  logic [NP-1:0] pre;
  logic [NS-1:0] sec, snap_s;
  logic [NM-1:0] min, snap_m;
  logic pre_tc, sec_tc, min_tc, tick, counting, capture, ovf;
  assign counting = state == RUN || state == SPLT;
  assign tick     = counting && pre_tc;
  assign capture  = !CLEAR && !STOP && !START && LAP && state == RUN;
  count_clr #(.MOD(PRESCALE), .W(NP)) u_pre (.CLK(CLK), .RSTn(RSTn), .CLR(CLEAR), .ENABLE(counting), .COUNT(pre), .TC(pre_tc));
  count_clr #(.MOD(SEC_MOD), .W(NS)) u_sec (.CLK(CLK), .RSTn(RSTn), .CLR(CLEAR), .ENABLE(tick), .COUNT(sec), .TC(sec_tc));
  count_clr #(.MOD(MIN_MOD), .W(NM)) u_min (.CLK(CLK), .RSTn(RSTn), .CLR(CLEAR), .ENABLE(tick && sec_tc), .COUNT(min), .TC(min_tc));
  // Highest-priority asserted command decides; it may be a no-op in the current state
  always_comb begin
    state_n = state;
    if (CLEAR) state_n = IDLE;
    else if (STOP) state_n = counting ? PAUSE : state;
    else if (START) state_n = counting ? state : RUN;
    else if (LAP) state_n = state == RUN ? SPLT : state == SPLT ? RUN : state;
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state  <= IDLE;
      snap_s <= '0;
      snap_m <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_n;
      ovf   <= !CLEAR && tick && sec_tc && min_tc;
      if (CLEAR) begin
        snap_s <= '0;
        snap_m <= '0;
      end else if (capture) begin
        snap_s <= sec;
        snap_m <= min;
      end
    end
  assign SEC_OUT = state == SPLT ? snap_s : sec;
  assign MIN_OUT = state == SPLT ? snap_m : min;
  assign RUNNING = counting;
  assign SPLIT   = state == SPLT;
  assign OVF     = ovf;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: two stopwatch configurations driven together and checked against an elapsed-time model
module tb_stopwatch_ctrl;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, clear = 0, lap = 0;
  logic [5:0] a_sec, a_min;
  logic [1:0] b_sec;
  logic [0:0] b_min;
  logic a_run, a_split, a_ovf, b_run, b_split, b_ovf;
  int tests = 0, fails = 0;
  localparam int MI = 0, MR = 1, MP = 2, MS = 3;
  int mode = MI, ticks = 0, snap = 0;
  logic counted = 0;
  wire counting = mode == MR || mode == MS;
  always #5 clk = ~clk;
  stopwatch_ctrl #(.PRESCALE(4), .SEC_MOD(60), .MIN_MOD(60)) dut_a (
    .CLK(clk), .RSTn(rst_n), .START(start), .STOP(stop), .CLEAR(clear), .LAP(lap),
    .SEC_OUT(a_sec), .MIN_OUT(a_min), .RUNNING(a_run), .SPLIT(a_split), .OVF(a_ovf));
  stopwatch_ctrl #(.PRESCALE(2), .SEC_MOD(3), .MIN_MOD(2)) dut_b (
    .CLK(clk), .RSTn(rst_n), .START(start), .STOP(stop), .CLEAR(clear), .LAP(lap),
    .SEC_OUT(b_sec), .MIN_OUT(b_min), .RUNNING(b_run), .SPLIT(b_split), .OVF(b_ovf));
  // Model tracks elapsed counting cycles; displayed time is derived arithmetically
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode <= MI;
      ticks <= 0;
      snap <= 0;
      counted <= 0;
    end else begin
      counted <= counting && !clear;
      if (clear) begin
        mode <= MI;
        ticks <= 0;
        snap <= 0;
      end else begin
        if (counting) ticks <= ticks + 1;
        if (stop) mode <= counting ? MP : mode;
        else if (start) mode <= counting ? mode : MR;
        else if (lap && mode == MR) begin
          mode <= MS;
          snap <= ticks;
        end else if (lap && mode == MS) mode <= MR;
      end
    end
  function int shown(input int per, input int md);
    return (((mode == MS) ? snap : ticks) / per) % md;
  endfunction
  function int ovf_exp(input int period);
    return int'(counted && ticks > 0 && ticks % period == 0);
  endfunction
  task chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task cmp();
    chk("a_sec", a_sec, shown(4, 60));
    chk("a_min", a_min, shown(240, 60));
    chk("a_run", a_run, int'(counting));
    chk("a_split", a_split, int'(mode == MS));
    chk("a_ovf", a_ovf, ovf_exp(14400));
    chk("b_sec", b_sec, shown(2, 3));
    chk("b_min", b_min, shown(6, 2));
    chk("b_run", b_run, int'(counting));
    chk("b_split", b_split, int'(mode == MS));
    chk("b_ovf", b_ovf, ovf_exp(12));
  endtask
  task step();
    @(negedge clk);
    cmp();
  endtask
  task cyc(input int n);
    repeat (n) step();
  endtask
  task pulse(input logic st, input logic sp, input logic cl, input logic lp);
    {start, stop, clear, lap} = {st, sp, cl, lp};
    step();
    {start, stop, clear, lap} = 4'b0;
  endtask
  initial begin
    cyc(2);
    chk("rst_sec", a_sec, 0);
    chk("rst_run", a_run, 0);
    chk("rst_ovf", a_ovf, 0);
    rst_n = 1;
    cyc(1);
    pulse(1, 0, 0, 0);
    chk("start_run", a_run, 1);
    chk("start_sec", a_sec, 0);
    cyc(4);
    chk("first_sec", a_sec, 1);
    cyc(16);
    chk("sec5", a_sec, 5);
    cyc(220);
    chk("min1_min", a_min, 1);
    chk("min1_sec", a_sec, 0);
    pulse(0, 0, 1, 0);
    chk("clr_sec", a_sec, 0);
    chk("clr_run", a_run, 0);
    pulse(1, 0, 0, 0);
    cyc(5);
    pulse(0, 1, 0, 0);
    cyc(50);
    chk("pause_sec", a_sec, 1);
    chk("pause_run", a_run, 0);
    pulse(1, 0, 0, 0);
    cyc(1);
    chk("resume1_sec", a_sec, 1);
    cyc(1);
    chk("resume2_sec", a_sec, 2);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    cyc(40);
    chk("pre_lap_sec", a_sec, 10);
    pulse(0, 0, 0, 1);
    chk("lap_split", a_split, 1);
    chk("lap_sec", a_sec, 10);
    cyc(39);
    chk("frozen_sec", a_sec, 10);
    chk("frozen_split", a_split, 1);
    pulse(0, 0, 0, 1);
    chk("unlap_split", a_split, 0);
    chk("unlap_sec", a_sec, 20);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    cyc(239);
    pulse(0, 0, 0, 1);
    chk("wraplap_sec", a_sec, 59);
    chk("wraplap_min", a_min, 0);
    pulse(0, 0, 0, 1);
    chk("wrapunlap_sec", a_sec, 0);
    chk("wrapunlap_min", a_min, 1);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    cyc(11);
    chk("b_pre_wrap_min", b_min, 1);
    chk("b_pre_wrap_sec", b_sec, 2);
    chk("b_pre_wrap_ovf", b_ovf, 0);
    cyc(1);
    chk("b_wrap_sec", b_sec, 0);
    chk("b_wrap_min", b_min, 0);
    chk("b_wrap_ovf", b_ovf, 1);
    cyc(1);
    chk("b_post_ovf", b_ovf, 0);
    cyc(1);
    chk("b_cont_sec", b_sec, 1);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    cyc(28);
    chk("prio_pre_sec", a_sec, 7);
    pulse(1, 1, 1, 0);
    chk("prio_sec", a_sec, 0);
    chk("prio_min", a_min, 0);
    chk("prio_run", a_run, 0);
    pulse(1, 0, 0, 1);
    chk("startlap_run", a_run, 1);
    chk("startlap_split", a_split, 0);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    cyc(332);
    chk("t123_min", a_min, 1);
    chk("t123_sec", a_sec, 23);
    pulse(0, 0, 0, 1);
    chk("t123_split", a_split, 1);
    #2 rst_n = 0;
    #1 cmp();
    chk("arst_sec", a_sec, 0);
    chk("arst_min", a_min, 0);
    chk("arst_run", a_run, 0);
    chk("arst_split", a_split, 0);
    step();
    rst_n = 1;
    cyc(10);
    chk("post_rst_run", a_run, 0);
    chk("post_rst_sec", a_sec, 0);
    pulse(1, 0, 0, 0);
    chk("post_rst_start", a_run, 1);
    cyc(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
